data_mem_sync: RTL



---
 rtl/data_mem_pkg.sv | 18 +
 rtl/byte_lane_ram.sv | 35 +++
 rtl/data_mem_sync.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and address helpers for the synchronous data memory.
// Helpers take the bytes-per-word count explicitly so any word width can use them.
package data_mem_pkg;

  typedef enum logic [0:0] {
    DM_IDLE,
    DM_SPLIT
  } dm_state_e;

  function automatic int unsigned word_idx(input int unsigned addr, input int unsigned nb);
    return addr / nb;
  endfunction

  function automatic int unsigned byte_off(input int unsigned addr, input int unsigned nb);
    return addr % nb;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-wide single-port RAM with per-byte write enables and a registered read port.
// The read register only updates on a read, so it holds the last word read.
module byte_lane_ram #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned WORDS     = 32768,
  parameter int unsigned IDX_W     = 15,
  parameter string       INIT_FILE = ""
) (
  input  logic                  i_clk,
  input  logic                  i_re,
  input  logic [DATA_W/8-1:0]   i_we,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [DATA_W-1:0]     i_wdata,
  output logic [DATA_W-1:0]     o_rdata
);

  localparam int unsigned NB = DATA_W / 8;

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++) begin
      if (i_we[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_sync.sv
// Synchronous little-endian data memory with valid/ready requests, byte enables,
// range checking and a two-step split for word-misaligned accesses.
module data_mem_sync
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH_BYTES = 65536,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned     NB     = DATA_W / 8;
  localparam int unsigned     WORDS  = DEPTH_BYTES / NB;
  localparam int unsigned     IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned     OFF_W  = (NB > 1) ? $clog2(NB) : 1;
  localparam longint unsigned ASPACE = 64'd1 << ADDR_W;

  dm_state_e r_state, w_state_d;

  int unsigned      w_off;
  longint unsigned  w_addr1;
  logic             w_mis, w_err, w_acc;
  logic [IDX_W-1:0] w_idx0, w_idx1;

  logic              r_write, r_err;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_be;
  logic [OFF_W-1:0]  r_off;
  logic [IDX_W-1:0]  r_idx1;

  logic              w_ram_re;
  logic [NB-1:0]     w_ram_we;
  logic [IDX_W-1:0]  w_ram_idx;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_rdata, w_merged;

  logic w_done, w_done_err, w_done_load, w_part0_rd;

  logic              r_rsp_valid, r_rsp_err;
  logic              r_fmt_mis, r_fmt_err, r_use_last;
  logic [OFF_W-1:0]  r_fmt_off;
  logic [DATA_W-1:0] r_lo, r_last;

  // Request decode: word indices of both parts and the per-byte range check.
  always_comb begin
    w_off   = byte_off(32'(req_addr), NB);
    w_mis   = (w_off != 0);
    w_addr1 = (64'(req_addr) - 64'(w_off) + 64'(NB)) % ASPACE;
    w_idx0  = IDX_W'(word_idx(32'(req_addr), NB));
    w_idx1  = IDX_W'(word_idx(32'(w_addr1), NB));
    w_err   = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (((64'(req_addr) + 64'(i)) % ASPACE) >= 64'(DEPTH_BYTES)) begin
        w_err = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    req_ready   = (r_state == DM_IDLE) && !rst;
    w_acc       = req_valid && req_ready;
    w_ram_re    = 1'b0;
    w_ram_we    = '0;
    w_ram_idx   = '0;
    w_ram_wdata = '0;
    w_done      = 1'b0;
    w_done_err  = 1'b0;
    w_done_load = 1'b0;
    w_part0_rd  = 1'b0;
    unique case (r_state)
      DM_IDLE: begin
        if (w_acc) begin
          if (w_mis) begin
            w_state_d = DM_SPLIT;
          end else begin
            w_done      = 1'b1;
            w_done_err  = w_err;
            w_done_load = !req_write;
          end
          w_part0_rd = w_mis && !req_write && !w_err;
          if (!w_err) begin
            w_ram_re  = !req_write;
            w_ram_idx = w_idx0;
            // Part 0 (or a whole aligned access): data byte j lands in lane off+j.
            for (int i = 0; i < NB; i++) begin
              if (i >= int'(w_off)) begin
                w_ram_we[i]          = req_write & req_be[i - int'(w_off)];
                w_ram_wdata[8*i +: 8] = req_wdata[8*(i - int'(w_off)) +: 8];
              end
            end
          end
        end
      end
      DM_SPLIT: begin
        w_state_d = DM_IDLE;
        if (!rst) begin
          w_done      = 1'b1;
          w_done_err  = r_err;
          w_done_load = !r_write;
          if (!r_err) begin
            w_ram_re  = !r_write;
            w_ram_idx = r_idx1;
            for (int i = 0; i < NB; i++) begin
              if (i < int'(r_off)) begin
                w_ram_we[i] = r_write & r_be[int'(NB) - int'(r_off) + i];
                w_ram_wdata[8*i +: 8] = r_wdata[8*(int'(NB) - int'(r_off) + i) +: 8];
              end
            end
          end
        end
      end
      default: w_state_d = DM_IDLE;
    endcase
  end

  byte_lane_ram #(
    .DATA_W    (DATA_W),
    .WORDS     (WORDS),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk   (clk),
    .i_re    (w_ram_re),
    .i_we    (w_ram_we),
    .i_idx   (w_ram_idx),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_write <= req_write;
      r_wdata <= req_wdata;
      r_be    <= req_be;
      r_off   <= OFF_W'(w_off);
      r_idx1  <= w_idx1;
      r_err   <= w_err;
    end
  end

  // The response word is rebuilt from the RAM read register (and the held part-0 word);
  // r_last freezes the visible value while a part-0 read disturbs the RAM register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= DM_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_last      <= '0;
      r_use_last  <= 1'b1;
      r_fmt_mis   <= 1'b0;
      r_fmt_err   <= 1'b0;
      r_fmt_off   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_rsp_valid <= w_done;
      r_rsp_err   <= w_done & w_done_err;
      if (w_done && w_done_load) begin
        r_use_last <= 1'b0;
        r_fmt_err  <= w_done_err;
        r_fmt_mis  <= (r_state == DM_SPLIT);
        r_fmt_off  <= r_off;
        if (r_state == DM_SPLIT) begin
          r_lo <= w_ram_rdata;
        end
      end else if (w_part0_rd) begin
        r_last     <= rsp_rdata;
        r_use_last <= 1'b1;
      end
    end
  end

  always_comb begin
    w_merged = w_ram_rdata;
    if (r_fmt_mis) begin
      for (int i = 0; i < NB; i++) begin
        if (i + int'(r_fmt_off) < int'(NB)) begin
          w_merged[8*i +: 8] = r_lo[8*(i + int'(r_fmt_off)) +: 8];
        end else begin
          w_merged[8*i +: 8] = w_ram_rdata[8*(i + int'(r_fmt_off) - int'(NB)) +: 8];
        end
      end
    end
    if (r_use_last) begin
      rsp_rdata = r_last;
    end else if (r_fmt_err) begin
      rsp_rdata = '0;
    end else begin
      rsp_rdata = w_merged;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;

endmodule
